control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle main control FSM for the 16-bit CPU. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects. It also produces the 2-bit AluOp consumed by the existing ALU control decoder and handshakes with a shared instruction/data memory port that may insert wait states.

## Interface
- No parameters. Instruction format: opcode = IR[15:12], func = IR[3:0]; func goes directly to ALU control, not through this block.
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- Opcode  in  4  IR[15:12]; valid from the cycle after IrWrite
- Zero  in  1  ALU zero flag, combinational from the current ALU operation
- MemReady  in  1  memory completes the current MemRead/MemWrite this cycle
- PcWrite  out  1  load PC
- PcSource  out  1  0 = ALU result, 1 = AluOut register (branch target)
- IorD  out  1  memory address: 0 = PC, 1 = AluOut
- MemRead, MemWrite  out  1 each  memory strobes, held until MemReady
- IrWrite  out  1  load IR
- RegWrite  out  1  register file write enable
- RegDst  out  1  0 = rt (IR[8:6]), 1 = rd (IR[5:3])
- MemToReg  out  1  0 = AluOut, 1 = memory data register
- AluSrcA  out  1  0 = PC, 1 = register A
- AluSrcB  out  2  00 = register B, 01 = constant 1, 10 = sign-extended imm, 11 = sign-extended imm (branch offset)
- AluOp  out  2  00 = add, 01 = subtract, 10 = decode by func
- Halted  out  1  core stopped by HALT
- Trap  out  1  illegal opcode; only with ILLEGAL_TRAP_EN
- State  out  3  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Opcodes:
  - 0000 = R-type
  - 0100 = ADDI
  - 1000 = LW
  - 1100 = SW
  - 0010 = BEQ
  - 1111 = HALT
  - any other value is illegal
- Outputs are Moore, decoded from state and an instruction class register. That register is latched on the DECODE→next transition. Two exceptions are Mealy: PcWrite/IrWrite in FETCH (gated by MemReady) and PcWrite in BEQ EXEC (gated by Zero).
- Any output not listed for a state is 0 in that state.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00.
  - MemReady=0: stay in FETCH.
  - MemReady=1: IrWrite=1 and PcWrite=1 (PcSource=0, PC+1) in the same cycle; go to DECODE.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00; the branch target is computed into AluOut.
  - R, ADDI, LW, SW, BEQ → EXEC.
  - HALT → HALT.
  - Illegal → TRAP, or FETCH when ILLEGAL_TRAP_EN is undefined.
- EXEC:
  - R-type: AluSrcA=1, AluSrcB=00, AluOp=10 → WB.
  - ADDI, LW, SW: AluSrcA=1, AluSrcB=10, AluOp=00. ADDI → WB; LW, SW → MEM.
  - BEQ: AluSrcA=1, AluSrcB=00, AluOp=01, PcSource=1, PcWrite=Zero → FETCH.
- MEM: IorD=1.
  - LW: MemRead=1.
  - SW: MemWrite=1.
  - Hold until MemReady=1, then LW → WB and SW → FETCH.
- WB: RegWrite=1 → FETCH.
  - R-type: RegDst=1, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
  - ADDI: RegDst=0, MemToReg=0.
- HALT: Halted=1 and all enables 0. The only exit is reset.

## Timing
- ResetN low, at any time including mid-access: state → FETCH and class → R immediately. While ResetN is low, every output is forced to 0 (State=0).
- The first FETCH strobes appear in the first cycle after ResetN deasserts.
- Instruction latency with zero-wait memory (MemReady always 1):
  - BEQ: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - HALT: 2 cycles to Halted.
- Each memory wait cycle adds 1 cycle.
- MemRead/MemWrite, IorD and all address selects stay stable while waiting. The strobe drops in the cycle after MemReady is sampled high.
- A MemReady pulse outside FETCH/MEM is ignored.
- Zero is sampled only in BEQ EXEC.
- Opcode changes in any state other than DECODE have no effect.
- IrWrite and PcWrite never assert in the same cycle as RegWrite or MemWrite.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE → TRAP. Trap=1, all enables 0, held until reset.
- ILLEGAL_TRAP_EN undefined:
  - No TRAP state and no Trap logic; the Trap output is tied to 0.
  - An illegal opcode is a 2-cycle NOP: DECODE → FETCH with no RegWrite or MemWrite.

## Test plan
- R-type, MemReady=1: State sequence 0,1,2,4,0. AluOp=10 only in EXEC; RegWrite=1, RegDst=1 only in WB; exactly one PcWrite, in FETCH.
- LW with 2 wait cycles in FETCH and 3 in MEM: MemRead=1 for 3 FETCH cycles (IorD=0) and 4 MEM cycles (IorD=1). WB has MemToReg=1, RegDst=0. Total 10 cycles.
- BEQ with Zero=1 then Zero=0: in EXEC, PcWrite=1 with PcSource=1 and AluOp=01 for the first; PcWrite=0 for the second. Both take 3 cycles.
- SW followed by HALT: MemWrite=1 in MEM and no RegWrite. HALT reaches Halted=1 and stays there for 20 cycles with all enables 0.
- Opcode 0111: with ILLEGAL_TRAP_EN, State=6 and Trap=1 held. Without it, State returns to 0 after DECODE and RegWrite/MemWrite stay 0.
- ResetN pulsed low during LW MEM wait: outputs go to 0 asynchronously. After release, State=0 with MemRead=1, IorD=0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Shared instruction/data memory port between the control sequencer and memory.
// The sequencer drives the strobes and the address select; memory returns MemReady.
interface control_sequencer_if;
    logic MemRead;
    logic MemWrite;
    logic IorD;
    logic MemReady;

    modport master (output MemRead, output MemWrite, output IorD, input MemReady);
    modport slave  (input MemRead, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle main control FSM for the 16-bit CPU: fetch/decode/exec/mem/wb sequencing.
// Optional build macro ILLEGAL_TRAP_EN adds a sticky TRAP state for illegal opcodes.
module control_sequencer (
    input  logic                       Clock,
    input  logic                       ResetN,
    control_sequencer_if.master        mem,
    input  logic [3:0]                 Opcode,
    input  logic                       Zero,
    output logic                       PcWrite,
    output logic                       PcSource,
    output logic                       IrWrite,
    output logic                       RegWrite,
    output logic                       RegDst,
    output logic                       MemToReg,
    output logic                       AluSrcA,
    output logic [1:0]                 AluSrcB,
    output logic [1:0]                 AluOp,
    output logic                       Halted,
    output logic                       Trap,
    output logic [2:0]                 State
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
`ifdef ILLEGAL_TRAP_EN
        ,
        ST_TRAP   = 3'd6
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_HALT,
        CLS_ILL
    } cls_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1100;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    state_t state;
    state_t next_state;
    cls_t   cls;
    cls_t   op_cls;

    always_comb begin
        case (Opcode)
            OP_R:    op_cls = CLS_R;
            OP_ADDI: op_cls = CLS_ADDI;
            OP_LW:   op_cls = CLS_LW;
            OP_SW:   op_cls = CLS_SW;
            OP_BEQ:  op_cls = CLS_BEQ;
            OP_HALT: op_cls = CLS_HALT;
            default: op_cls = CLS_ILL;
        endcase
    end

    // Opcode is only trusted in DECODE; the class register carries it for the rest of the instruction.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_FETCH;
            cls   <= CLS_R;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state <= next_state;
            if (state == ST_DECODE) begin
                cls <= op_cls;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (mem.MemReady) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op_cls)
                    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ: next_state = ST_EXEC;
                    CLS_HALT:                                 next_state = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:                                  next_state = ST_TRAP;
`else
                    default:                                  next_state = ST_FETCH;
`endif
                endcase
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R, CLS_ADDI: next_state = ST_WB;
                    CLS_LW, CLS_SW:  next_state = ST_MEM;
                    default:         next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem.MemReady) begin
                    next_state = (cls == CLS_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   next_state = ST_FETCH;
            ST_HALT: next_state = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: next_state = ST_TRAP;
`endif
            default: next_state = ST_FETCH;
        endcase
    end

    // Outputs are held at zero while ResetN is low, so the FETCH decode cannot leak during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        PcWrite      = 1'b0;
        PcSource     = 1'b0;
        IrWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        AluSrcA      = 1'b0;
        AluSrcB      = SRCB_REG;
        AluOp        = ALU_ADD;
        Halted       = 1'b0;
        Trap         = 1'b0;
        State        = 3'd0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        mem.IorD     = 1'b0;

        if (ResetN) begin
            State = state;
            case (state)
                ST_FETCH: begin
                    mem.MemRead = 1'b1;
                    AluSrcB     = SRCB_ONE;
                    IrWrite     = mem.MemReady;
                    PcWrite     = mem.MemReady;
                end
                ST_DECODE: begin
                    AluSrcB = SRCB_BOFF;
                end
                ST_EXEC: begin
                    AluSrcA = 1'b1;
                    case (cls)
                        CLS_R: begin
                            AluOp = ALU_FUNC;
                        end
                        CLS_ADDI, CLS_LW, CLS_SW: begin
                            AluSrcB = SRCB_IMM;
                        end
                        CLS_BEQ: begin
                            AluOp    = ALU_SUB;
                            PcSource = 1'b1;
                            PcWrite  = Zero;
                        end
                        default: begin
                            AluSrcA = 1'b0;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem.IorD     = 1'b1;
                    mem.MemRead  = (cls == CLS_LW);
                    mem.MemWrite = (cls == CLS_SW);
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (cls == CLS_R);
                    MemToReg = (cls == CLS_LW);
                end
                ST_HALT: begin
                    Halted = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    Trap = 1'b1;
                end
`endif
                default: begin
                    State = state;
                end
            endcase
        end
    end

    a_no_fetch_write_overlap: assert property (@(posedge Clock) disable iff (!ResetN)
        !((IrWrite || PcWrite) && (RegWrite || mem.MemWrite)));

    a_single_strobe: assert property (@(posedge Clock) disable iff (!ResetN)
        !(mem.MemRead && mem.MemWrite));

    a_mem_wait_stable: assert property (@(posedge Clock) disable iff (!ResetN)
        (state == ST_MEM && !mem.MemReady) |=> (mem.IorD && state == ST_MEM));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; builds with or without ILLEGAL_TRAP_EN.
module tb_control_sequencer;

    logic       Clock;
    logic       ResetN;
    logic [3:0] Opcode;
    logic       Zero;
    logic       PcWrite, PcSource, IrWrite, RegWrite, RegDst, MemToReg, AluSrcA;
    logic [1:0] AluSrcB, AluOp;
    logic       Halted, Trap;
    logic [2:0] State;

    int checks   = 0;
    int failures = 0;

    control_sequencer_if mif ();

    control_sequencer dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .mem      (mif.master),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .PcWrite  (PcWrite),
        .PcSource (PcSource),
        .IrWrite  (IrWrite),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .AluSrcA  (AluSrcA),
        .AluSrcB  (AluSrcB),
        .AluOp    (AluOp),
        .Halted   (Halted),
        .Trap     (Trap),
        .State    (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Field order: PcWrite PcSource IorD MemRead MemWrite IrWrite RegWrite RegDst MemToReg
    //              AluSrcA AluSrcB[1:0] AluOp[1:0] Halted Trap State[2:0]
    logic [18:0] outs;
    assign outs = {PcWrite, PcSource, mif.IorD, mif.MemRead, mif.MemWrite, IrWrite, RegWrite,
                   RegDst, MemToReg, AluSrcA, AluSrcB, AluOp, Halted, Trap, State};

    localparam logic [18:0] V_ZERO    = 19'b0;
    localparam logic [18:0] F_RDY     = 19'b1_0_0_1_0_1_0_0_0_0_01_00_0_0_000;
    localparam logic [18:0] F_WAIT    = 19'b0_0_0_1_0_0_0_0_0_0_01_00_0_0_000;
    localparam logic [18:0] DEC       = 19'b0_0_0_0_0_0_0_0_0_0_11_00_0_0_001;
    localparam logic [18:0] EX_R      = 19'b0_0_0_0_0_0_0_0_0_1_00_10_0_0_010;
    localparam logic [18:0] EX_I      = 19'b0_0_0_0_0_0_0_0_0_1_10_00_0_0_010;
    localparam logic [18:0] EX_BEQ_T  = 19'b1_1_0_0_0_0_0_0_0_1_00_01_0_0_010;
    localparam logic [18:0] EX_BEQ_N  = 19'b0_1_0_0_0_0_0_0_0_1_00_01_0_0_010;
    localparam logic [18:0] MEM_LW    = 19'b0_0_1_1_0_0_0_0_0_0_00_00_0_0_011;
    localparam logic [18:0] MEM_SW    = 19'b0_0_1_0_1_0_0_0_0_0_00_00_0_0_011;
    localparam logic [18:0] WB_R      = 19'b0_0_0_0_0_0_1_1_0_0_00_00_0_0_100;
    localparam logic [18:0] WB_LW     = 19'b0_0_0_0_0_0_1_0_1_0_00_00_0_0_100;
    localparam logic [18:0] WB_I      = 19'b0_0_0_0_0_0_1_0_0_0_00_00_0_0_100;
    localparam logic [18:0] V_HALT    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_1_0_101;
    localparam logic [18:0] V_TRAP    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_0_1_110;

    typedef struct packed {
        logic [3:0]  op;
        logic        rdy;
        logic        z;
        logic [18:0] want;
    } step_t;

    function automatic step_t mk(logic [3:0] op, logic rdy, logic z, logic [18:0] want);
        step_t s;
        s.op   = op;
        s.rdy  = rdy;
        s.z    = z;
        s.want = want;
        return s;
    endfunction

    task automatic apply_reset();
        @(negedge Clock);
        ResetN   = 1'b0;
        MemReady_drive(1'b0);
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    task automatic MemReady_drive(input logic v);
        mif.MemReady = v;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        Opcode = 4'hF;
        Zero   = 1'b1;
        mif.MemReady = 1'b1;
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            failures++;
            $display("FAIL reset_low: outs=%b want=%b", outs, V_ZERO);
        end
        @(posedge Clock);
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            failures++;
            $display("FAIL reset_held: outs=%b want=%b", outs, V_ZERO);
        end
        @(negedge Clock);
        mif.MemReady = 1'b0;
        ResetN = 1'b1;
        #1;
        checks++;
        if (outs !== F_WAIT) begin
            failures++;
            $display("FAIL reset_first_fetch: outs=%b want=%b", outs, F_WAIT);
        end
    endtask

    task automatic test_rtype();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b1010, 1'b1, 1'b1, F_RDY));
        seq.push_back(mk(4'b0000, 1'b1, 1'b0, DEC));
        seq.push_back(mk(4'b1111, 1'b1, 1'b1, EX_R));
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, WB_R));
        seq.push_back(mk(4'b0000, 1'b0, 1'b0, F_WAIT));
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL rtype cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_addi();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b0100, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b0100, 1'b0, 1'b0, DEC));
        seq.push_back(mk(4'b0100, 1'b0, 1'b1, EX_I));
        seq.push_back(mk(4'b0100, 1'b0, 1'b0, WB_I));
        seq.push_back(mk(4'b0100, 1'b0, 1'b0, F_WAIT));
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL addi cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_lw_wait();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, F_WAIT));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, F_WAIT));
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, DEC));
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, EX_I));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, MEM_LW));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, MEM_LW));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, MEM_LW));
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, MEM_LW));
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, WB_LW));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, F_WAIT));
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL lw_wait cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_beq();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b0010, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b0010, 1'b0, 1'b1, DEC));
        seq.push_back(mk(4'b0010, 1'b0, 1'b1, EX_BEQ_T));
        seq.push_back(mk(4'b0010, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b0010, 1'b0, 1'b1, DEC));
        seq.push_back(mk(4'b0010, 1'b1, 1'b0, EX_BEQ_N));
        seq.push_back(mk(4'b0010, 1'b0, 1'b1, F_WAIT));
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL beq cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_sw_halt();
        step_t seq[$];
        logic [3:0] junk;
        apply_reset();
        seq.push_back(mk(4'b1100, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b1100, 1'b0, 1'b0, DEC));
        seq.push_back(mk(4'b1100, 1'b0, 1'b0, EX_I));
        seq.push_back(mk(4'b1100, 1'b0, 1'b0, MEM_SW));
        seq.push_back(mk(4'b1100, 1'b1, 1'b0, MEM_SW));
        seq.push_back(mk(4'b1111, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b1111, 1'b1, 1'b0, DEC));
        for (int k = 0; k < 20; k++) begin
            junk = k[3:0];
            seq.push_back(mk(junk, 1'b1, k[0], V_HALT));
        end
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL sw_halt cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_illegal();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b0111, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b0111, 1'b1, 1'b0, DEC));
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 5; k++) begin
            seq.push_back(mk(4'b0000, 1'b1, 1'b1, V_TRAP));
        end
`else
        seq.push_back(mk(4'b0000, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b0000, 1'b0, 1'b0, DEC));
        seq.push_back(mk(4'b0000, 1'b0, 1'b0, EX_R));
        seq.push_back(mk(4'b0000, 1'b0, 1'b0, WB_R));
        seq.push_back(mk(4'b0000, 1'b0, 1'b0, F_WAIT));
`endif
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL illegal cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset_mid_access();
        step_t seq[$];
        apply_reset();
        seq.push_back(mk(4'b1000, 1'b1, 1'b0, F_RDY));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, DEC));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, EX_I));
        seq.push_back(mk(4'b1000, 1'b0, 1'b0, MEM_LW));
        foreach (seq[i]) begin
            Opcode = seq[i].op; mif.MemReady = seq[i].rdy; Zero = seq[i].z;
            #1;
            checks++;
            if (outs !== seq[i].want) begin
                failures++;
                $display("FAIL reset_mid cycle %0d: outs=%b want=%b", i, outs, seq[i].want);
            end
            @(negedge Clock);
        end
        #2;
        ResetN = 1'b0;
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            failures++;
            $display("FAIL reset_mid_async: outs=%b want=%b", outs, V_ZERO);
        end
        @(posedge Clock);
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            failures++;
            $display("FAIL reset_mid_held: outs=%b want=%b", outs, V_ZERO);
        end
        @(negedge Clock);
        ResetN = 1'b1;
        #1;
        checks++;
        if (outs !== F_WAIT) begin
            failures++;
            $display("FAIL reset_mid_release: outs=%b want=%b", outs, F_WAIT);
        end
        mif.MemReady = 1'b1;
        #1;
        checks++;
        if (outs !== F_RDY) begin
            failures++;
            $display("FAIL reset_mid_refetch: outs=%b want=%b", outs, F_RDY);
        end
        @(negedge Clock);
        mif.MemReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_beq();
        test_sw_halt();
        test_illegal();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
